// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// the round-robin tie-break rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Single requester wins outright; on a tie the one not served last wins.
    function automatic logic rr_choose(input logic [1:0] valid, input logic last);
        if (valid == 2'b11) begin
            return ~last;
        end
        return valid[1];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; grant is only meaningful when
// at least one valid bit is set.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant
);

    assign grant = rr_choose(valid, last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one memory port with a single outstanding
// transaction: arbitrate in IDLE, present in REQ, wait for the response in RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    input  logic                  req0_we_i,
    output logic                  req0_rvalid_o,
    output logic [DATA_WIDTH-1:0] req0_rdata_o,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    input  logic                  req1_we_i,
    output logic                  req1_rvalid_o,
    output logic [DATA_WIDTH-1:0] req1_rdata_o,

    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  mem_we_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    arb_state_t r_state;
    logic       grant_q;
    logic       last_q;

    logic       w_pick;
    logic       w_in_req;
    logic       w_in_resp;

    rr_pick2 u_rr_pick2 (
        .valid ({req1_valid_i, req0_valid_i}),
        .last  (last_q),
        .grant (w_pick)
    );

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_valid_i || req1_valid_i) begin
                        grant_q <= w_pick;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        last_q  <= grant_q;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_in_req  = (r_state == REQ);
    assign w_in_resp = (r_state == RESP);

    // Payload is steered straight from the granted requester, which holds it
    // stable until accepted; outside REQ the bus is driven to zero.
    assign mem_valid_o = w_in_req;
    assign mem_addr_o  = w_in_req ? (grant_q ? req1_addr_i  : req0_addr_i)  : '0;
    assign mem_wdata_o = w_in_req ? (grant_q ? req1_wdata_i : req0_wdata_i) : '0;
    assign mem_we_o    = w_in_req & (grant_q ? req1_we_i : req0_we_i);

    assign req0_ready_o = w_in_req & ~grant_q & mem_ready_i;
    assign req1_ready_o = w_in_req &  grant_q & mem_ready_i;

    assign req0_rvalid_o = w_in_resp & mem_rvalid_i & ~grant_q;
    assign req1_rvalid_o = w_in_resp & mem_rvalid_i &  grant_q;

    assign req0_rdata_o = mem_rdata_i;
    assign req1_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req0_valid_i, req1_valid_i;
    logic          req0_ready_o, req1_ready_o;
    logic [AW-1:0] req0_addr_i, req1_addr_i;
    logic [DW-1:0] req0_wdata_i, req1_wdata_i;
    logic          req0_we_i, req1_we_i;
    logic          req0_rvalid_o, req1_rvalid_o;
    logic [DW-1:0] req0_rdata_o, req1_rdata_o;
    logic          mem_valid_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_we_o;
    logic          mem_ready_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_addr_i   (req0_addr_i),
        .req0_wdata_i  (req0_wdata_i),
        .req0_we_i     (req0_we_i),
        .req0_rvalid_o (req0_rvalid_o),
        .req0_rdata_o  (req0_rdata_o),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_addr_i   (req1_addr_i),
        .req1_wdata_i  (req1_wdata_i),
        .req1_we_i     (req1_we_i),
        .req1_rvalid_o (req1_rvalid_o),
        .req1_rdata_o  (req1_rdata_o),
        .mem_valid_o   (mem_valid_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_we_o      (mem_we_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0; req0_we_i = 1'b0;
        req1_valid_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0; req1_we_i = 1'b0;
        mem_ready_i  = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, 64'({mem_valid_o, mem_we_o, req0_ready_o, req1_ready_o,
                                req0_rvalid_o, req1_rvalid_o}), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata_o), 64'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        chk_quiet("in_reset");
        rst_i = 1'b0;
        tick();
        chk_quiet("after_reset");
    endtask

    // Transaction-level model state for the randomized run
    bit            pend [2];
    bit            clr  [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata [2];
    logic          p_we [2];
    bit            active, accepted, g, last_served, prev_idle, idle_now;
    bit            exp_mv, exp_rdy0, exp_rdy1, exp_rv0, exp_rv1;
    logic [1:0]    prev_valid, cur_valid;
    logic [AW-1:0] got [3];
    int            n_got;

    initial begin
        do_reset();

        // Single read
        req0_valid_i = 1'b1; req0_addr_i = 32'h100; req0_we_i = 1'b0;
        #1 chk("rd_c0_mem_valid", 64'(mem_valid_o), 64'd0);
        tick();
        mem_ready_i = 1'b1;
        #1;
        chk("rd_c1_mem_valid", 64'(mem_valid_o), 64'd1);
        chk("rd_c1_addr", 64'(mem_addr_o), 64'h100);
        chk("rd_c1_we", 64'(mem_we_o), 64'd0);
        chk("rd_c1_ready", 64'({req0_ready_o, req1_ready_o}), 64'b10);
        tick();
        req0_valid_i = 1'b0; mem_ready_i = 1'b0;
        #1 chk("rd_c2_quiet", 64'({mem_valid_o, req0_rvalid_o, req1_rvalid_o}), 64'd0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("rd_c3_rvalid", 64'({req0_rvalid_o, req1_rvalid_o}), 64'b10);
        chk("rd_c3_rdata", 64'(req0_rdata_o), 64'hDEADBEEF);
        chk("rd_c3_ready", 64'({req0_ready_o, req1_ready_o}), 64'd0);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        #1 chk_quiet("rd_done");

        // Spurious response while idle
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
        #1 chk("spur_rvalid0", 64'({req0_rvalid_o, req1_rvalid_o}), 64'd0);
        tick();
        chk("spur_rvalid1", 64'({mem_valid_o, req0_rvalid_o, req1_rvalid_o}), 64'd0);
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Backpressure, with a stray response while in REQ
        req0_valid_i = 1'b1; req0_addr_i = 32'h44;
        tick();
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp_addr%0d", i), 64'({mem_valid_o, mem_addr_o}), 64'({1'b1, 32'h44}));
            chk($sformatf("bp_hold%0d", i), 64'({req0_ready_o, req1_ready_o, req0_rvalid_o, req1_rvalid_o}), 64'd0);
            tick();
        end
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b0;
        #1 chk("bp_accept", 64'({req0_ready_o, mem_addr_o}), 64'({1'b1, 32'h44}));
        tick();
        req0_valid_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5;
        #1 chk("bp_rvalid", 64'({req0_rvalid_o, req1_rvalid_o}), 64'b10);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Write from requester 1
        req1_valid_i = 1'b1; req1_we_i = 1'b1; req1_addr_i = 32'h8; req1_wdata_i = 32'h55;
        tick();
        mem_ready_i = 1'b1;
        #1;
        chk("wr_we", 64'(mem_we_o), 64'd1);
        chk("wr_wdata", 64'(mem_wdata_o), 64'h55);
        chk("wr_addr", 64'(mem_addr_o), 64'h8);
        chk("wr_ready", 64'({req0_ready_o, req1_ready_o}), 64'b01);
        tick();
        req1_valid_i = 1'b0; req1_we_i = 1'b0; req1_wdata_i = '0; mem_ready_i = 1'b0;
        mem_rvalid_i = 1'b1;
        #1 chk("wr_rvalid", 64'({req0_rvalid_o, req1_rvalid_o}), 64'b01);
        tick();
        mem_rvalid_i = 1'b0;

        // Tie after reset: grants alternate starting with requester 0
        do_reset();
        req0_valid_i = 1'b1; req0_addr_i = 32'h10;
        req1_valid_i = 1'b1; req1_addr_i = 32'h20;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b1;
        n_got = 0;
        got = '{default: '0};
        for (int i = 0; i < 9; i++) begin
            tick();
            if (mem_valid_o) begin
                if (n_got < 3) got[n_got] = mem_addr_o;
                n_got++;
            end
        end
        idle_inputs();
        chk("tie_count", 64'(n_got), 64'd3);
        chk("tie_addr0", 64'(got[0]), 64'h10);
        chk("tie_addr1", 64'(got[1]), 64'h20);
        chk("tie_addr2", 64'(got[2]), 64'h10);
        tick();

        // Reset while waiting for the response
        req0_valid_i = 1'b1; req0_addr_i = 32'h300;
        tick();
        mem_ready_i = 1'b1;
        tick();
        req0_valid_i = 1'b0; mem_ready_i = 1'b0;
        rst_i = 1'b1;
        #1 chk_quiet("rst_resp");
        #1 rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE;
        #1 chk("rst_late_rv0", 64'({req0_rvalid_o, req1_rvalid_o}), 64'd0);
        tick();
        chk("rst_late_rv1", 64'({mem_valid_o, req0_rvalid_o, req1_rvalid_o}), 64'd0);
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        req0_valid_i = 1'b1; req0_addr_i = 32'h11;
        req1_valid_i = 1'b1; req1_addr_i = 32'h22;
        tick();
        chk("rst_tie_req0", 64'({mem_valid_o, mem_addr_o}), 64'({1'b1, 32'h11}));
        mem_ready_i = 1'b1;
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;

        // Randomized traffic against the transaction model
        do_reset();
        pend = '{default: 1'b0};
        clr  = '{default: 1'b0};
        active = 1'b0; accepted = 1'b0; g = 1'b0;
        last_served = 1'b1; prev_idle = 1'b1; prev_valid = 2'b00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (clr[n]) pend[n] = 1'b0;
                clr[n] = 1'b0;
                if (!pend[n] && $urandom_range(0, 99) < 40) begin
                    pend[n]    = 1'b1;
                    p_addr[n]  = $urandom;
                    p_wdata[n] = $urandom;
                    p_we[n]    = 1'($urandom_range(0, 1));
                end
            end
            req0_valid_i = pend[0]; req0_addr_i = p_addr[0]; req0_wdata_i = p_wdata[0]; req0_we_i = p_we[0];
            req1_valid_i = pend[1]; req1_addr_i = p_addr[1]; req1_wdata_i = p_wdata[1]; req1_we_i = p_we[1];
            mem_ready_i  = ($urandom_range(0, 99) < 60);
            mem_rvalid_i = ($urandom_range(0, 99) < 40);
            mem_rdata_i  = $urandom;
            #1;
            cur_valid = {pend[1], pend[0]};
            // A transaction is presented the cycle after an idle cycle with requests
            if (!active && prev_idle && prev_valid != 2'b00) begin
                active   = 1'b1;
                accepted = 1'b0;
                g = (prev_valid == 2'b11) ? ~last_served : prev_valid[1];
            end
            idle_now = !active;
            exp_mv   = active && !accepted;
            exp_rdy0 = exp_mv && mem_ready_i && !g;
            exp_rdy1 = exp_mv && mem_ready_i && g;
            exp_rv0  = active && accepted && mem_rvalid_i && !g;
            exp_rv1  = active && accepted && mem_rvalid_i && g;
            chk($sformatf("rnd%0d_mem_valid", cyc), 64'(mem_valid_o), 64'(exp_mv));
            if (exp_mv) begin
                chk($sformatf("rnd%0d_addr", cyc), 64'(mem_addr_o), 64'(p_addr[g]));
                chk($sformatf("rnd%0d_wdata", cyc), 64'(mem_wdata_o), 64'(p_wdata[g]));
                chk($sformatf("rnd%0d_we", cyc), 64'(mem_we_o), 64'(p_we[g]));
            end
            chk($sformatf("rnd%0d_ready", cyc), 64'({req0_ready_o, req1_ready_o}), 64'({exp_rdy0, exp_rdy1}));
            chk($sformatf("rnd%0d_rvalid", cyc), 64'({req0_rvalid_o, req1_rvalid_o}), 64'({exp_rv0, exp_rv1}));
            if (exp_rv0 || exp_rv1) begin
                chk($sformatf("rnd%0d_rdata", cyc), 64'(g ? req1_rdata_o : req0_rdata_o), 64'(mem_rdata_i));
            end
            if (exp_mv && mem_ready_i) begin
                accepted = 1'b1;
                clr[g]   = 1'b1;
            end else if (active && accepted && mem_rvalid_i) begin
                active      = 1'b0;
                last_served = g;
            end
            prev_idle  = idle_now;
            prev_valid = cur_valid;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
